dp_datamem: RTL and testbench
=============================

# dp_datamem

Parametrised true dual-port data memory with per-byte write enables, registered read outputs with valid strobes, and defined same-address collision behaviour. Successor to the fixed 32-bit single-behaviour data memory; serves as the core's data RAM. Port A is the load/store port and port B the debug/DMA port. An optional post-reset clear sweep zeroes the array before either port is accepted.

## Interface
- DATA_W, 32, data width in bits; multiple of 8.
- ADDR_W, 10, address width; depth is 2**ADDR_W words.
- READ_MODE, 0, same-port read-during-write: 0 returns old data (read-first), 1 returns new data (write-first).
- NB, DATA_W/8, derived byte-lane count; not overridden.

- clk  in  1  clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ena  in  1  port A access request.
- wea  in  NB  port A byte write mask; 0 means read only.
- addra  in  ADDR_W  port A word address.
- dina  in  DATA_W  port A write data.
- douta  out  DATA_W  port A registered read data.
- valida  out  1  douta updated this cycle.
- enb, web, addrb, dinb, doutb, validb: port B, identical to port A.
- busy  out  1  clear sweep in progress; port requests ignored.

## Operation
- Every accepted access (en=1, busy=0) performs a read. Lanes with we[i]=1 are also written.
- douta/doutb change only on an accepted access and hold their value otherwise.
- Same-port write lanes return per READ_MODE: old contents (0) or din lanes (1). Unwritten lanes always return the stored value.
- Cross-port read of an address the other port writes in the same cycle returns the old contents.
- Both ports write the same address in the same cycle: for overlapping lanes port A's data is stored; non-overlapping lanes each take their own port's data.
- Addresses are fully decoded; there is no out-of-range case.
- Requests while busy=1 are dropped: no write, no read, no valid pulse.
- Without the clear sweep, the array is not reset; contents survive rst_n.

## Timing
- Reset values: douta=0, doutb=0, valida=0, validb=0, busy=1 with the clear macro and 0 without it.
- Read latency is 1 cycle. A request sampled at edge N produces dout and valid=1 after edge N. valid drops after edge N+1 unless there is another request.
- Write data is visible to either port on a read sampled at edge N+1 or later.
- Clear sweep states:
  - IDLE → CLEAR on reset release. CLEAR writes zero to address k at each edge, k = 0 … 2**ADDR_W−1.
  - busy deasserts after the edge that writes the last address, so the sweep takes 2**ADDR_W cycles.
  - Requests are accepted from the next edge on.
- Reset mid-sweep: the sweep aborts immediately, busy stays 1, and the sweep restarts at address 0 after release.

## Configuration
- DP_DATAMEM_CLEAR_EN defined: the clear sweep FSM and address counter are built, and busy behaves as above.
- DP_DATAMEM_CLEAR_EN undefined: busy is tied to 0, no counter is built, the ports are usable on the first edge after reset release, and initial contents are undefined.

## Test plan
- Reset, then A writes 0xDEADBEEF at 0x005 with wea=0xF, then A reads 0x005 → next cycle douta=0xDEADBEEF, valida=1; the following idle cycle gives valida=0 and douta held.
- Byte merge: word 0x010 = 0x11223344, A writes 0xAABBCCDD with wea=0x5 → B read gives doutb=0x11BB33DD.
- Read-during-write at 0x020 (old 0x1, A writes 0x2): READ_MODE=0 → douta=0x1; READ_MODE=1 → douta=0x2; B reading 0x020 in the same cycle returns doutb=0x1.
- Collision: A writes 0xAAAAAAAA with wea=0x3, B writes 0xBBBBBBBB with web=0xE at 0x030 → a later read returns 0xBBBBAAAA.
- With DP_DATAMEM_CLEAR_EN, ADDR_W=4: busy=1 for exactly 16 cycles after release; a request at cycle 3 gives no valid pulse; every address then reads 0. Pulse rst_n low at cycle 8 → busy stays high and the sweep runs 16 more cycles from 0.
- Reset asserted with douta=0xDEADBEEF → douta=0 and valida=0 asynchronously, before the next clock edge.

Source files
------------

// File: rtl/dp_datamem.sv
// True dual-port data memory: per-byte write enables, registered reads with valid strobes.
// Define DP_DATAMEM_CLEAR_EN to build the post-reset zeroing sweep that drives busy.
module dp_datamem #(
  parameter  int DATA_W    = 32,
  parameter  int ADDR_W    = 10,
  parameter  int READ_MODE = 0,
  localparam int NB        = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [NB-1:0]     wea,
  input  logic [ADDR_W-1:0] addra,
  input  logic [DATA_W-1:0] dina,
  output logic [DATA_W-1:0] douta,
  output logic              valida,
  input  logic              enb,
  input  logic [NB-1:0]     web,
  input  logic [ADDR_W-1:0] addrb,
  input  logic [DATA_W-1:0] dinb,
  output logic [DATA_W-1:0] doutb,
  output logic              validb,
  output logic              busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              acc_a;
  logic              acc_b;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;

`ifdef DP_DATAMEM_CLEAR_EN
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  logic [0:0]        state;
  logic [ADDR_W-1:0] clr_addr;
  logic              clr_we;

  // Reset parks the sweep at word 0, so the first edge after release already clears it
  // and a reset mid-sweep restarts from the beginning.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_CLEAR;
      clr_addr <= '0;
    end else if (state == ST_CLEAR) begin
      clr_addr <= clr_addr + 1'b1;
      if (clr_addr == '1) state <= ST_IDLE;
    end
  end

  assign busy   = (state == ST_CLEAR);
  assign clr_we = busy & rst_n;
`else
  assign busy = 1'b0;
`endif

  assign acc_a = ena & ~busy;
  assign acc_b = enb & ~busy;

  // NOTE: the array has no reset branch; a RAM macro cannot be reset, and putting
  // it in the async-reset block below would turn it into a huge flop bank.
  always_ff @(posedge clk) begin
`ifdef DP_DATAMEM_CLEAR_EN
    if (clr_we) mem[clr_addr] <= '0;
`endif
    // Port A is applied last so it owns any lane both ports write this cycle.
    for (int i = 0; i < NB; i++) begin
      if (acc_b && web[i]) mem[addrb][i*8 +: 8] <= dinb[i*8 +: 8];
      if (acc_a && wea[i]) mem[addra][i*8 +: 8] <= dina[i*8 +: 8];
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no path
  // through it can leave a value unassigned and infer a latch.
  always_comb begin
    rd_a = mem[addra];
    rd_b = mem[addrb];
    if (READ_MODE == 1) begin
      for (int i = 0; i < NB; i++) begin
        if (wea[i]) rd_a[i*8 +: 8] = dina[i*8 +: 8];
        if (web[i]) rd_b[i*8 +: 8] = dinb[i*8 +: 8];
      end
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      douta  <= '0;
      valida <= 1'b0;
      doutb  <= '0;
      validb <= 1'b0;
    end else begin
      valida <= acc_a;
      validb <= acc_b;
      if (acc_a) douta <= rd_a;
      if (acc_b) doutb <= rd_b;
    end
  end

endmodule

// File: tb/tb_dp_datamem.sv
// Self-checking bench for dp_datamem: directed cases plus random traffic against a
// word/byte-lane reference model; read-first and write-first instances run side by side.
module tb_dp_datamem;

  localparam int AW    = 6;
  localparam int DEPTH = 2 ** AW;

`ifdef DP_DATAMEM_CLEAR_EN
  localparam logic BUSY_RST = 1'b1;
`else
  localparam logic BUSY_RST = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ena, enb;
  logic [3:0]    wea, web;
  logic [AW-1:0] addra, addrb;
  logic [31:0]   dina, dinb;
  logic [31:0]   da [2];
  logic [31:0]   db [2];
  logic          va [2];
  logic          vb [2];
  logic          bz [2];

  always #5 clk = ~clk;

  dp_datamem #(.DATA_W(32), .ADDR_W(AW), .READ_MODE(0)) u_rf (
    .clk(clk), .rst_n(rst_n),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(da[0]), .valida(va[0]),
    .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(db[0]), .validb(vb[0]),
    .busy(bz[0]));

  dp_datamem #(.DATA_W(32), .ADDR_W(AW), .READ_MODE(1)) u_wf (
    .clk(clk), .rst_n(rst_n),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(da[1]), .valida(va[1]),
    .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(db[1]), .validb(vb[1]),
    .busy(bz[1]));

`ifdef DP_DATAMEM_CLEAR_EN
  logic        rstc, enc, enbc, validc, validbc, busyc;
  logic [3:0]  addrc, addrbc, wec, webc;
  logic [31:0] dinc, dinbc, doutc, doutbc;

  dp_datamem #(.DATA_W(32), .ADDR_W(4), .READ_MODE(0)) u_clr (
    .clk(clk), .rst_n(rstc),
    .ena(enc), .wea(wec), .addra(addrc), .dina(dinc), .douta(doutc), .valida(validc),
    .enb(enbc), .web(webc), .addrb(addrbc), .dinb(dinbc), .doutb(doutbc), .validb(validbc),
    .busy(busyc));
`endif

  // Reference model: word contents plus which byte lanes hold a defined value.
  logic [31:0] mm [DEPTH];
  logic [3:0]  kn [DEPTH];
  logic [31:0] exp_da [2];
  logic [31:0] exp_db [2];
  logic [3:0]  exp_ma [2];
  logic [3:0]  exp_mb [2];
  logic        exp_va, exp_vb;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mix(input logic [31:0] base, input logic [31:0] nw,
                                      input logic [3:0] m);
    logic [31:0] r = base;
    for (int i = 0; i < 4; i++) if (m[i]) r[i*8 +: 8] = nw[i*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] lanes(input logic [3:0] m);
    logic [31:0] r = '0;
    for (int i = 0; i < 4; i++) r[i*8 +: 8] = {8{m[i]}};
    return r;
  endfunction

  task automatic check_outputs();
    for (int m = 0; m < 2; m++) begin
      check($sformatf("m%0d.douta", m), da[m] & lanes(exp_ma[m]), exp_da[m] & lanes(exp_ma[m]));
      check($sformatf("m%0d.doutb", m), db[m] & lanes(exp_mb[m]), exp_db[m] & lanes(exp_mb[m]));
      check($sformatf("m%0d.valida", m), {31'b0, va[m]}, {31'b0, exp_va});
      check($sformatf("m%0d.validb", m), {31'b0, vb[m]}, {31'b0, exp_vb});
    end
  endtask

  // One clock: the inputs set before the edge are applied, the model advances, outputs compared.
  task automatic step();
    logic [31:0] oa, ob;
    logic [3:0]  ka, kb;
    @(posedge clk);
    @(negedge clk);
    oa = mm[addra]; ob = mm[addrb];
    ka = kn[addra]; kb = kn[addrb];
    for (int m = 0; m < 2; m++) begin
      if (ena) begin
        exp_da[m] = (m == 1) ? mix(oa, dina, wea) : oa;
        exp_ma[m] = (m == 1) ? (ka | wea) : ka;
      end
      if (enb) begin
        exp_db[m] = (m == 1) ? mix(ob, dinb, web) : ob;
        exp_mb[m] = (m == 1) ? (kb | web) : kb;
      end
    end
    exp_va = ena;
    exp_vb = enb;
    if (enb) begin mm[addrb] = mix(mm[addrb], dinb, web); kn[addrb] = kn[addrb] | web; end
    if (ena) begin mm[addra] = mix(mm[addra], dina, wea); kn[addra] = kn[addra] | wea; end
    check_outputs();
  endtask

  task automatic idle();
    ena = 1'b0; enb = 1'b0; wea = '0; web = '0;
  endtask

  task automatic acc_a(input logic [AW-1:0] a, input logic [3:0] we, input logic [31:0] d);
    ena = 1'b1; addra = a; wea = we; dina = d;
  endtask

  task automatic acc_b(input logic [AW-1:0] a, input logic [3:0] we, input logic [31:0] d);
    enb = 1'b1; addrb = a; web = we; dinb = d;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (bz[0] === 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("ready", {31'b0, bz[0]}, 32'b0);
`ifdef DP_DATAMEM_CLEAR_EN
    for (int a = 0; a < DEPTH; a++) begin mm[a] = '0; kn[a] = 4'hF; end
`endif
  endtask

  task automatic reset_model_outputs();
    for (int m = 0; m < 2; m++) begin
      exp_da[m] = '0; exp_db[m] = '0; exp_ma[m] = 4'hF; exp_mb[m] = 4'hF;
    end
    exp_va = 1'b0; exp_vb = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    addra = '0; addrb = '0; dina = '0; dinb = '0;
    for (int a = 0; a < DEPTH; a++) begin mm[a] = 'x; kn[a] = 4'h0; end
    reset_model_outputs();
`ifdef DP_DATAMEM_CLEAR_EN
    rstc = 1'b0; enc = 1'b0; enbc = 1'b0; addrc = '0; addrbc = '0;
    wec = '0; webc = '0; dinc = '0; dinbc = '0;
`endif

    #1;
    check_outputs();
    check("busy_rst", {31'b0, bz[0]}, {31'b0, BUSY_RST});
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready();

    // Full write then read-back, then an idle cycle with the data held.
    acc_a(6'h05, 4'hF, 32'hDEADBEEF); step();
    acc_a(6'h05, 4'h0, 32'h0);        step();
    check("rd_deadbeef", da[0], 32'hDEADBEEF);
    idle();                           step();
    check("hold_deadbeef", da[0], 32'hDEADBEEF);

    // Byte-lane merge seen from the other port.
    acc_a(6'h10, 4'hF, 32'h11223344); step();
    acc_a(6'h10, 4'h5, 32'hAABBCCDD); step();
    idle(); acc_b(6'h10, 4'h0, 32'h0); step();
    check("merge_b", db[0], 32'h11BB33DD);

    // Read-during-write on A with a simultaneous cross-port read.
    idle(); acc_a(6'h20, 4'hF, 32'h1); step();
    acc_a(6'h20, 4'hF, 32'h2); acc_b(6'h20, 4'h0, 32'h0); step();
    check("rdw_rf_a", da[0], 32'h1);
    check("rdw_wf_a", da[1], 32'h2);
    check("rdw_rf_b", db[0], 32'h1);
    check("rdw_wf_b", db[1], 32'h1);

    // Same-cycle write collision: A owns the overlapping lane.
    acc_a(6'h30, 4'h3, 32'hAAAAAAAA); acc_b(6'h30, 4'hE, 32'hBBBBBBBB); step();
    idle(); acc_a(6'h30, 4'h0, 32'h0); step();
    check("collide", da[0], 32'hBBBBAAAA);

    // Async reset while a valid read is on the outputs.
    acc_a(6'h05, 4'h0, 32'h0); step();
    idle();
    #2 rst_n = 1'b0;
    #1;
    reset_model_outputs();
    check("arst_douta", da[0], 32'h0);
    check("arst_valida", {31'b0, va[0]}, 32'h0);
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready();
    acc_a(6'h05, 4'h0, 32'h0); step();
    idle(); step();

    // Define every word, then random traffic weighted toward address collisions.
    for (int i = 0; i < DEPTH / 2; i++) begin
      acc_a(AW'(2 * i), 4'hF, $urandom);
      acc_b(AW'(2 * i + 1), 4'hF, $urandom);
      step();
    end
    for (int i = 0; i < 400; i++) begin
      logic narrow;
      narrow = ($urandom_range(0, 3) != 0);
      ena = 1'($urandom); enb = 1'($urandom);
      wea = 4'($urandom); web = 4'($urandom);
      addra = narrow ? AW'($urandom_range(0, 3)) : AW'($urandom);
      addrb = narrow ? AW'($urandom_range(0, 3)) : AW'($urandom);
      dina = $urandom; dinb = $urandom;
      step();
    end
    idle(); step();

`ifdef DP_DATAMEM_CLEAR_EN
    begin
      int n;
      @(negedge clk);
      rstc = 1'b1;
      n = 0;
      while (busyc === 1'b1 && n < 200) begin @(negedge clk); n++; end
      check("clr_first_done", {31'b0, busyc}, 32'h0);
      for (int a = 0; a < 16; a++) begin
        enc = 1'b1; addrc = 4'(a); wec = 4'hF; dinc = 32'hC0DE0000 | 32'(a + 1);
        @(negedge clk);
      end
      enc = 1'b0; wec = '0;
      rstc = 1'b0;
      #1 check("clr_busy_rst", {31'b0, busyc}, 32'h1);
      @(negedge clk);
      rstc = 1'b1;
      for (int c = 1; c <= 8; c++) begin
        @(posedge clk);
        @(negedge clk);
        check("clr_busy_p1", {31'b0, busyc}, 32'h1);
        check("clr_novalid_p1", {31'b0, validc}, 32'h0);
        enc = (c == 3); addrc = 4'h2;
      end
      enc = 1'b0;
      #2 rstc = 1'b0;
      #1 check("clr_busy_mid", {31'b0, busyc}, 32'h1);
      @(negedge clk);
      rstc = 1'b1;
      n = 0;
      do begin
        @(posedge clk);
        @(negedge clk);
        n++;
        check("clr_novalid_p2", {31'b0, validc}, 32'h0);
      end while (busyc === 1'b1 && n < 100);
      check("clr_cycles", 32'(n), 32'd16);
      for (int a = 0; a < 16; a++) begin
        enc = 1'b1; addrc = 4'(a);
        @(posedge clk);
        @(negedge clk);
        check($sformatf("clr_zero_%0d", a), doutc, 32'h0);
        check("clr_valid", {31'b0, validc}, 32'h1);
      end
      enc = 1'b0;
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
